// File: rtl/bus_resp_pkg.sv
// Shared types and helpers for the 68030-style bus response model.
// Holds the FSM and decode enums, SIZE/FC encodings and the byte-lane helper.
package bus_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_e;

  typedef enum logic [1:0] {MEM, IACK, ERR} class_e;

  localparam logic [1:0] SIZE_LONG  = 2'b00;
  localparam logic [1:0] SIZE_BYTE  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_3BYTE = 2'b11;

  localparam logic [2:0] FC_CPU_SPACE = 3'b111;

  // Big-endian byte enables: bit i is lane i, lane 0 = D31:24.
  // The transfer never crosses the 32-bit port, so it is clipped at lane 3.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a10);
    logic [2:0] nBytes;
    logic [2:0] room;
    logic [2:0] first;
    logic [2:0] lane;
    logic [3:0] mask;
    nBytes = (size == SIZE_LONG) ? 3'd4 : {1'b0, size};
    first  = {1'b0, a10};
    room   = 3'd4 - first;
    if (room < nBytes) nBytes = room;
    mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      lane = 3'(i);
      if ((lane >= first) && (lane < (first + nBytes))) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/bus_resp_ram.sv
// Single-port-style RAM backing the bus model: per-byte write enables,
// registered read, no reset so contents survive across bus resets.
module bus_resp_ram
  import bus_resp_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] wrAddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] rdAddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [2**AW];

  // be_i[b] selects big-endian lane b, i.e. bits 31-8b down to 24-8b.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i && be_i[b]) mem[wrAddr_i][31-8*b -: 8] <= wdata_i[31-8*b -: 8];
    end
    rdata_o <= mem[rdAddr_i];
  end

endmodule

// File: rtl/bus_resp_model.sv
// Asynchronous 68030 bus slave: decodes each cycle into RAM, IACK or bus
// error, waits a fixed number of clocks and returns a registered termination.
module bus_resp_model
  import bus_resp_pkg::*;
#(
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 2,
  parameter int SYNC_TERM   = 0,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      ADR_IN,
  input  logic [31:0]      CPU_DATA,
  input  logic             ASn,
  input  logic             DSn,
  input  logic             RWn,
  input  logic [1:0]       SIZE,
  input  logic [2:0]       FC,
  output logic [31:0]      DATA_IN,
  output logic [1:0]       DSACKn,
  output logic             STERMn,
  output logic             BERRn,
  output logic             AVECn,
  output logic [CNT_W-1:0] RESP_COUNT
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : gBadWaitStates
    $error("bus_resp_model: WAIT_STATES must be in 0..15");
  end

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_e             state_q;
  class_e             cls_q;
  logic [3:0]         waitCnt_q;
  logic [MEM_AW+1:0]  adr_q;
  logic               rwn_q;
  logic [1:0]         size_q;
  logic [31:0]        dataIn_q;
  logic [1:0]         dsack_q;
  logic               sterm_q;
  logic               berr_q;
  logic               avec_q;
  logic [CNT_W-1:0]   count_q;

  logic               inRam;
  class_e             decodeCls;
  logic               goResp;
  logic               ramWe;
  logic [3:0]         ramBe;
  logic [MEM_AW-1:0]  ramRdAddr;
  logic [31:0]        ramRdata;

  assign inRam     = (ADR_IN[31:MEM_AW+2] == '0);
  assign decodeCls = (FC == FC_CPU_SPACE) ? IACK : (inRam ? MEM : ERR);
  assign goResp    = (state_q == WAIT) && !ASn && (waitCnt_q == 4'd0) && (rwn_q || !DSn);
  assign ramWe     = goResp && (cls_q == MEM) && !rwn_q;
  assign ramBe     = lane_mask(size_q, adr_q[1:0]);

  // Read ADR_IN directly while idle so the word is ready even with zero wait states.
  assign ramRdAddr = (state_q == IDLE) ? ADR_IN[MEM_AW+1:2] : adr_q[MEM_AW+1:2];

  bus_resp_ram #(.AW(MEM_AW)) uRam (
    .clk_i    (CLK),
    .we_i     (ramWe),
    .be_i     (ramBe),
    .wrAddr_i (adr_q[MEM_AW+1:2]),
    .wdata_i  (CPU_DATA),
    .rdAddr_i (ramRdAddr),
    .rdata_o  (ramRdata)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cls_q     <= MEM;
      waitCnt_q <= 4'd0;
      adr_q     <= '0;
      rwn_q     <= 1'b1;
      size_q    <= SIZE_LONG;
      dataIn_q  <= 32'h0;
      dsack_q   <= 2'b11;
      sterm_q   <= 1'b1;
      berr_q    <= 1'b1;
      avec_q    <= 1'b1;
      count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!ASn) begin
            state_q   <= WAIT;
            waitCnt_q <= WAIT_INIT;
            cls_q     <= decodeCls;
            adr_q     <= ADR_IN[MEM_AW+1:0];
            rwn_q     <= RWn;
            size_q    <= SIZE;
          end
        end
        WAIT: begin
          if (ASn) begin
            state_q <= IDLE;
          end else if (waitCnt_q != 4'd0) begin
            waitCnt_q <= waitCnt_q - 4'd1;
          end else if (goResp) begin
            state_q <= RESP;
            case (cls_q)
              MEM: begin
                if (SYNC_TERM != 0) sterm_q <= 1'b0;
                else                dsack_q <= 2'b00;
              end
              IACK:    avec_q <= 1'b0;
              default: berr_q <= 1'b0;
            endcase
            if (rwn_q) dataIn_q <= (cls_q == MEM) ? ramRdata : 32'h0;
            if (count_q != '1) count_q <= count_q + CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= HOLD;
          sterm_q <= 1'b1;
        end
        HOLD: begin
          if (ASn) begin
            state_q <= IDLE;
            dsack_q <= 2'b11;
            berr_q  <= 1'b1;
            avec_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DATA_IN    = dataIn_q;
  assign DSACKn     = dsack_q;
  assign STERMn     = sterm_q;
  assign BERRn      = berr_q;
  assign AVECn      = avec_q;
  assign RESP_COUNT = count_q;

endmodule

// File: tb/tb_bus_resp_model.sv
// Directed bench for bus_resp_model: an async-terminating instance and a
// STERM instance share one stimulus stream and are checked against hand values.
module tb_bus_resp_model;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] ADR_IN;
  logic [31:0] CPU_DATA;
  logic        ASn;
  logic        DSn;
  logic        RWn;
  logic [1:0]  SIZE;
  logic [2:0]  FC;

  logic [31:0] DATA_IN,  DATA_INS;
  logic [1:0]  DSACKn,   DSACKnS;
  logic        STERMn,   STERMnS;
  logic        BERRn,    BERRnS;
  logic        AVECn,    AVECnS;
  logic [15:0] RESP_COUNT, RESP_COUNTS;

  int assertCount = 0;
  int failCount   = 0;
  int expCount    = 0;
  int edges;

  logic [1:0]  respDsack, holdDsack, endDsack, respDsackS;
  logic        respBerr, respAvec, respSterm, respStermS, holdStermS;
  logic        endBerr, endAvec;
  logic [31:0] respData, endData;

  bus_resp_model #(.MEM_AW(10), .WAIT_STATES(2), .SYNC_TERM(0), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .ADR_IN(ADR_IN), .CPU_DATA(CPU_DATA), .ASn(ASn),
    .DSn(DSn), .RWn(RWn), .SIZE(SIZE), .FC(FC), .DATA_IN(DATA_IN), .DSACKn(DSACKn),
    .STERMn(STERMn), .BERRn(BERRn), .AVECn(AVECn), .RESP_COUNT(RESP_COUNT)
  );

  bus_resp_model #(.MEM_AW(10), .WAIT_STATES(2), .SYNC_TERM(1), .CNT_W(16)) dutS (
    .CLK(CLK), .RESET(RESET), .ADR_IN(ADR_IN), .CPU_DATA(CPU_DATA), .ASn(ASn),
    .DSn(DSn), .RWn(RWn), .SIZE(SIZE), .FC(FC), .DATA_IN(DATA_INS), .DSACKn(DSACKnS),
    .STERMn(STERMnS), .BERRn(BERRnS), .AVECn(AVECnS), .RESP_COUNT(RESP_COUNTS)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Runs one full bus cycle; DSn is held high for dsLag edges on writes.
  task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] wdata, input logic rwn,
                               input logic [1:0] size, input logic [2:0] fc, input int dsLag);
    bit seen;
    seen  = 1'b0;
    edges = 0;
    @(negedge CLK);
    ADR_IN = adr; CPU_DATA = wdata; RWn = rwn; SIZE = size; FC = fc; ASn = 1'b0;
    DSn = (rwn || dsLag == 0) ? 1'b0 : 1'b1;
    while (!seen && edges < 40) begin
      @(posedge CLK); #1;
      edges++;
      if (DSACKn != 2'b11 || !BERRn || !AVECn || !STERMnS) begin
        seen = 1'b1;
        respDsack = DSACKn; respBerr = BERRn; respAvec = AVECn; respSterm = STERMn;
        respStermS = STERMnS; respDsackS = DSACKnS; respData = DATA_IN;
      end else if (edges >= dsLag) begin
        DSn = 1'b0;
      end
    end
    checkOutput("respSeen", 32'(seen), 32'd1);
    @(negedge CLK);
    ASn = 1'b1; DSn = 1'b1;
    @(posedge CLK); #1;
    holdDsack = DSACKn; holdStermS = STERMnS;
    @(posedge CLK); #1;
    endDsack = DSACKn; endBerr = BERRn; endAvec = AVECn; endData = DATA_IN;
  endtask

  task automatic checkCycle(input string tag, input int expEdges, input logic [1:0] expDsack,
                            input logic expBerr, input logic expAvec);
    expCount++;
    checkOutput({tag, ".edges"},    32'(edges),      32'(expEdges));
    checkOutput({tag, ".dsack"},    32'(respDsack),  32'(expDsack));
    checkOutput({tag, ".berr"},     32'(respBerr),   32'(expBerr));
    checkOutput({tag, ".avec"},     32'(respAvec),   32'(expAvec));
    checkOutput({tag, ".sterm"},    32'(respSterm),  32'd1);
    checkOutput({tag, ".holdDs"},   32'(holdDsack),  32'(expDsack));
    checkOutput({tag, ".endDs"},    32'(endDsack),   32'h3);
    checkOutput({tag, ".endBerr"},  32'(endBerr),    32'd1);
    checkOutput({tag, ".endAvec"},  32'(endAvec),    32'd1);
    checkOutput({tag, ".count"},    32'(RESP_COUNT), 32'(expCount));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET = 1'b1; ADR_IN = '0; CPU_DATA = '0; ASn = 1'b1; DSn = 1'b1;
    RWn = 1'b1; SIZE = 2'b00; FC = 3'b101;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RESET = 1'b0;
    @(posedge CLK); #1;
    checkOutput("rst.dsack",  32'(DSACKn),     32'h3);
    checkOutput("rst.sterm",  32'(STERMnS),    32'd1);
    checkOutput("rst.berr",   32'(BERRn),      32'd1);
    checkOutput("rst.avec",   32'(AVECn),      32'd1);
    checkOutput("rst.data",   DATA_IN,         32'h0);
    checkOutput("rst.count",  32'(RESP_COUNT), 32'd0);

    applyStimulus(32'h10, 32'hDEADBEEF, 1'b0, 2'b00, 3'b101, 0);
    checkCycle("wrLong", 4, 2'b00, 1'b1, 1'b1);
    applyStimulus(32'h10, 32'h0, 1'b1, 2'b00, 3'b101, 0);
    checkCycle("rdLong", 4, 2'b00, 1'b1, 1'b1);
    checkOutput("rdLong.data",    respData,          32'hDEADBEEF);
    checkOutput("rdLong.hold",    endData,           32'hDEADBEEF);
    checkOutput("sync.sterm",     32'(respStermS),   32'd0);
    checkOutput("sync.dsack",     32'(respDsackS),   32'h3);
    checkOutput("sync.oneClk",    32'(holdStermS),   32'd1);

    applyStimulus(32'h10, 32'h0, 1'b0, 2'b00, 3'b101, 0);
    checkCycle("clr", 4, 2'b00, 1'b1, 1'b1);
    applyStimulus(32'h13, 32'hA5A5A5A5, 1'b0, 2'b01, 3'b101, 0);
    checkCycle("wrByte", 4, 2'b00, 1'b1, 1'b1);
    applyStimulus(32'h10, 32'h0, 1'b1, 2'b00, 3'b101, 0);
    checkCycle("rdByte", 4, 2'b00, 1'b1, 1'b1);
    checkOutput("rdByte.data", respData, 32'h000000A5);

    applyStimulus(32'h12, 32'h12341234, 1'b0, 2'b10, 3'b101, 0);
    checkCycle("wrWord", 4, 2'b00, 1'b1, 1'b1);
    applyStimulus(32'h10, 32'h0, 1'b1, 2'b00, 3'b101, 0);
    checkCycle("rdWord", 4, 2'b00, 1'b1, 1'b1);
    checkOutput("rdWord.data", respData, 32'h00001234);

    applyStimulus(32'h14, 32'hFFFFFFFF, 1'b0, 2'b00, 3'b101, 0);
    checkCycle("fill5", 4, 2'b00, 1'b1, 1'b1);
    applyStimulus(32'h15, 32'h11223344, 1'b0, 2'b00, 3'b101, 0);
    checkCycle("wrMis", 4, 2'b00, 1'b1, 1'b1);
    applyStimulus(32'h14, 32'h0, 1'b1, 2'b00, 3'b101, 0);
    checkCycle("rdMis", 4, 2'b00, 1'b1, 1'b1);
    checkOutput("rdMis.data", respData, 32'hFF223344);

    applyStimulus(32'h14, 32'h5A5A5A5A, 1'b0, 2'b01, 3'b101, 8);
    checkCycle("dsLate", 9, 2'b00, 1'b1, 1'b1);
    applyStimulus(32'h14, 32'h0, 1'b1, 2'b00, 3'b101, 0);
    checkCycle("rdLate", 4, 2'b00, 1'b1, 1'b1);
    checkOutput("rdLate.data", respData, 32'h5A223344);

    applyStimulus(32'h14, 32'h0, 1'b1, 2'b00, 3'b111, 0);
    checkCycle("iack", 4, 2'b11, 1'b1, 1'b0);
    checkOutput("iack.data", respData, 32'h0);

    applyStimulus(32'h10, 32'h0, 1'b1, 2'b00, 3'b101, 0);
    checkCycle("rdAgain", 4, 2'b00, 1'b1, 1'b1);
    checkOutput("rdAgain.data", respData, 32'h00001234);
    applyStimulus(32'h8000_0000, 32'h0, 1'b1, 2'b00, 3'b101, 0);
    checkCycle("berr", 4, 2'b11, 1'b0, 1'b1);
    checkOutput("berr.data", respData, 32'h0);

    // Abort: ASn rises while the slave is still counting wait states.
    @(negedge CLK);
    ADR_IN = 32'h10; RWn = 1'b1; SIZE = 2'b00; FC = 3'b101; ASn = 1'b0; DSn = 1'b0;
    @(posedge CLK);
    @(negedge CLK); ASn = 1'b1; DSn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      checkOutput("abort.dsack", 32'(DSACKn),  32'h3);
      checkOutput("abort.sterm", 32'(STERMnS), 32'd1);
    end
    checkOutput("abort.count", 32'(RESP_COUNT), 32'(expCount));

    // Reset while DSACKn is held in HOLD by a still-asserted ASn.
    @(negedge CLK);
    ADR_IN = 32'h10; RWn = 1'b1; ASn = 1'b0; DSn = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    checkOutput("rstHold.resp", 32'(DSACKn), 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rstHold.held", 32'(DSACKn), 32'h0);
    #2 RESET = 1'b1;
    #1;
    checkOutput("rstHold.dsack", 32'(DSACKn),     32'h3);
    checkOutput("rstHold.count", 32'(RESP_COUNT), 32'd0);
    checkOutput("rstHold.data",  DATA_IN,         32'h0);
    @(negedge CLK);
    RESET = 1'b0; ASn = 1'b1; DSn = 1'b1;
    expCount = 0;
    applyStimulus(32'h10, 32'h0, 1'b1, 2'b00, 3'b101, 0);
    checkCycle("postRst", 4, 2'b00, 1'b1, 1'b1);
    checkOutput("postRst.data", respData, 32'h00001234);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
